// File: rtl/flash_resp_tx.sv
// Serialises one flash read result into an ASCII reply frame for the UART TX byte interface.
// Data frame: 'D' <addr> ':' <hex digits, MS nibble first> CR LF. Error frame: "ERR" CR LF.
module flash_resp_tx #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ACK_TIMEOUT = 1023,
  parameter int unsigned CNT_W       = 10
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              rd_valid,
  input  logic              rd_err,
  input  logic [7:0]        rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_byte,
  output logic              resp_busy,
  output logic              resp_done,
  output logic              drop_err
);

  localparam int unsigned NIBBLES = DATA_W / 4;
  localparam int unsigned IDX_W   = 5;

  typedef enum logic [2:0] {StIdle, StSend, StWaitHi, StWaitLo, StNext} state_e;

  state_e            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;
  logic [7:0]        addr_q;
  logic [DATA_W-1:0] data_q;
  logic [7:0]        tx_byte_q;
  logic [IDX_W-1:0]  last_idx;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [7:0] frame_byte(input logic              err,
                                            input logic [7:0]        addr,
                                            input logic [DATA_W-1:0] data,
                                            input logic [IDX_W-1:0]  idx);
    logic [DATA_W-1:0] sh;
    int unsigned       i;
    logic [7:0]        b;
    i  = 32'(idx);
    sh = '0;
    b  = 8'h0A;
    if (err) begin
      case (i)
        0:       b = 8'h45;
        1, 2:    b = 8'h52;
        3:       b = 8'h0D;
        default: b = 8'h0A;
      endcase
    end else if (i == 0) begin
      b = 8'h44;
    end else if (i == 1) begin
      b = addr;
    end else if (i == 2) begin
      b = 8'h3A;
    end else if (i < NIBBLES + 3) begin
      // Index 3 carries the most significant nibble.
      sh = data >> (4 * (NIBBLES + 2 - i));
      b  = hex_char(sh[3:0]);
    end else if (i == NIBBLES + 3) begin
      b = 8'h0D;
    end
    return b;
  endfunction

  assign last_idx  = err_q ? IDX_W'(4) : IDX_W'(NIBBLES + 4);
  assign resp_busy = (state_q != StIdle);
  // Combinational so the first byte can start the cycle after capture.
  assign tx_start  = (state_q == StSend) && !tx_busy;
  // NEXT still counts as busy, so a coincident rd_valid is dropped.
  assign resp_done = (state_q == StNext) && (idx_q == last_idx);
  assign drop_err  = rd_valid && resp_busy;
  assign tx_byte   = tx_byte_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      tx_byte_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (rd_valid) begin
            err_q     <= rd_err;
            addr_q    <= rd_addr;
            data_q    <= rd_data;
            idx_q     <= '0;
            tx_byte_q <= frame_byte(rd_err, rd_addr, rd_data, '0);
            state_q   <= StSend;
          end
        end
        StSend: begin
          if (!tx_busy) begin
            cnt_q   <= '0;
            state_q <= StWaitHi;
          end
        end
        StWaitHi: begin
          if (tx_busy) begin
            state_q <= StWaitLo;
          end else if (cnt_q == CNT_W'(ACK_TIMEOUT)) begin
            state_q <= StNext;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWaitLo: begin
          if (!tx_busy) begin
            state_q <= StNext;
          end
        end
        StNext: begin
          if (idx_q == last_idx) begin
            state_q <= StIdle;
          end else begin
            idx_q     <= idx_q + 1'b1;
            tx_byte_q <= frame_byte(err_q, addr_q, data_q, idx_q + 1'b1);
            state_q   <= StSend;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_resp_tx.sv
// Directed bench for flash_resp_tx with a simple UART TX busy model and byte logger.
module tb_flash_resp_tx;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ACK_TO  = 15;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic              rd_valid;
  logic              rd_err;
  logic [7:0]        rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              tx_busy;
  logic              tx_start;
  logic [7:0]        tx_byte;
  logic              resp_busy;
  logic              resp_done;
  logic              drop_err;

  logic              model_busy = 1'b0;
  logic              force_busy;
  int                busy_left  = 0;
  int                busy_len;
  int                cyc        = 0;
  int                done_cnt   = 0;
  int                drop_cnt   = 0;
  logic [7:0]        captured[$];
  int                start_cyc[$];
  logic [7:0]        exp_q[$];

  int                n_checks   = 0;
  int                n_fail     = 0;

  assign tx_busy = model_busy | force_busy;

  always #5 sys_clk = ~sys_clk;

  flash_resp_tx #(
    .DATA_W      (DATA_W),
    .ACK_TIMEOUT (ACK_TO),
    .CNT_W       (10)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rd_valid  (rd_valid),
    .rd_err    (rd_err),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_byte   (tx_byte),
    .resp_busy (resp_busy),
    .resp_done (resp_done),
    .drop_err  (drop_err)
  );

  // UART model: latch the byte on tx_start, then hold busy for busy_len cycles.
  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
    if (!sys_rst_n) begin
      model_busy <= 1'b0;
      busy_left  <= 0;
    end else begin
      if (resp_done) done_cnt++;
      if (drop_err) drop_cnt++;
      if (tx_start) begin
        captured.push_back(tx_byte);
        start_cyc.push_back(cyc);
        if (busy_len > 0) begin
          model_busy <= 1'b1;
          busy_left  <= busy_len;
        end
      end else if (busy_left > 1) begin
        busy_left <= busy_left - 1;
      end else if (busy_left == 1) begin
        busy_left  <= 0;
        model_busy <= 1'b0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    captured.delete();
    start_cyc.delete();
    done_cnt = 0;
    drop_cnt = 0;
  endtask

  task automatic check_frame(input string tag);
    check_eq({tag, "_len"}, captured.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < captured.size(); i++) begin
      check_eq(tag, {24'h0, captured[i]}, {24'h0, exp_q[i]});
    end
  endtask

  task automatic send(input logic err, input logic [7:0] addr, input logic [DATA_W-1:0] data,
                      input logic exp_start);
    @(negedge sys_clk);
    rd_valid = 1'b1;
    rd_err   = err;
    rd_addr  = addr;
    rd_data  = data;
    @(posedge sys_clk);
    #1;
    rd_valid = 1'b0;
    check_eq("lat_busy", resp_busy, 1);
    check_eq("lat_start", tx_start, exp_start);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge sys_clk);
    while (resp_busy && n < 1000) begin
      @(negedge sys_clk);
      n++;
    end
    check_eq(tag, resp_busy, 0);
  endtask

  task automatic wait_bytes(input int cnt, input string tag);
    int n = 0;
    while (captured.size() < cnt && n < 1000) begin
      @(negedge sys_clk);
      n++;
    end
    check_eq(tag, (captured.size() >= cnt), 1);
  endtask

  initial begin
    int min_gap;
    int n;
    sys_rst_n  = 1'b0;
    rd_valid   = 1'b0;
    rd_err     = 1'b0;
    rd_addr    = '0;
    rd_data    = '0;
    force_busy = 1'b0;
    busy_len   = 8;
    repeat (3) @(negedge sys_clk);
    check_eq("rst_tx_start", tx_start, 0);
    check_eq("rst_tx_byte", tx_byte, 0);
    check_eq("rst_resp_busy", resp_busy, 0);
    check_eq("rst_resp_done", resp_done, 0);
    check_eq("rst_drop_err", drop_err, 0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Data frame 0x1A2F at address '5'
    clear_log();
    send(1'b0, 8'h35, 16'h1A2F, 1'b1);
    check_eq("first_byte", tx_byte, 8'h44);
    wait_idle("data_idle");
    exp_q = '{8'h44, 8'h35, 8'h3A, 8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A};
    check_frame("data_frame");
    check_eq("data_done_cnt", done_cnt, 1);
    check_eq("data_hold_byte", tx_byte, 8'h0A);

    // Error frame ignores addr/data
    clear_log();
    send(1'b1, 8'h39, 16'hFFFF, 1'b1);
    wait_idle("err_idle");
    exp_q = '{8'h45, 8'h52, 8'h52, 8'h0D, 8'h0A};
    check_frame("err_frame");
    check_eq("err_done_cnt", done_cnt, 1);

    // UART busy when the request arrives
    clear_log();
    force_busy = 1'b1;
    send(1'b0, 8'h37, 16'hBEEF, 1'b0);
    repeat (20) @(negedge sys_clk);
    check_eq("busy_no_start", captured.size(), 0);
    force_busy = 1'b0;
    #1;
    check_eq("busy_release_start", tx_start, 1);
    check_eq("busy_release_byte", tx_byte, 8'h44);
    wait_idle("busy_idle");
    exp_q = '{8'h44, 8'h37, 8'h3A, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    check_frame("busy_frame");

    // Second request during byte 4, then another coincident with resp_done
    clear_log();
    send(1'b0, 8'h41, 16'h09C3, 1'b1);
    wait_bytes(4, "drop_reach4");
    @(negedge sys_clk);
    rd_valid = 1'b1;
    rd_addr  = 8'h42;
    rd_data  = 16'h5555;
    #1;
    check_eq("drop_pulse", drop_err, 1);
    @(negedge sys_clk);
    rd_valid = 1'b0;
    n = 0;
    while (!resp_done && n < 1000) begin
      @(negedge sys_clk);
      n++;
    end
    check_eq("drop_see_done", resp_done, 1);
    check_eq("drop_cnt_mid", drop_cnt, 1);
    rd_valid = 1'b1;
    #1;
    check_eq("done_coincide_drop", drop_err, 1);
    @(negedge sys_clk);
    rd_valid = 1'b0;
    check_eq("done_coincide_idle", resp_busy, 0);
    repeat (5) @(negedge sys_clk);
    exp_q = '{8'h44, 8'h41, 8'h3A, 8'h30, 8'h39, 8'h43, 8'h33, 8'h0D, 8'h0A};
    check_frame("drop_frame");
    check_eq("drop_done_cnt", done_cnt, 1);
    check_eq("drop_cnt_total", drop_cnt, 2);

    // UART never raises busy: each byte relies on the ack timeout
    clear_log();
    busy_len = 0;
    send(1'b0, 8'h35, 16'h1A2F, 1'b1);
    wait_idle("to_idle");
    exp_q = '{8'h44, 8'h35, 8'h3A, 8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A};
    check_frame("to_frame");
    check_eq("to_done_cnt", done_cnt, 1);
    min_gap = 1000;
    for (int i = 1; i < start_cyc.size(); i++) begin
      if (start_cyc[i] - start_cyc[i-1] < min_gap) min_gap = start_cyc[i] - start_cyc[i-1];
    end
    check_eq("to_gap_ok", (min_gap >= int'(ACK_TO)) && (min_gap <= int'(ACK_TO) + 4), 1);

    // Reset during byte 5 abandons the frame
    clear_log();
    busy_len = 8;
    send(1'b0, 8'h35, 16'h1A2F, 1'b1);
    wait_bytes(5, "rst_reach5");
    sys_rst_n = 1'b0;
    #1;
    check_eq("midrst_tx_start", tx_start, 0);
    check_eq("midrst_resp_busy", resp_busy, 0);
    check_eq("midrst_resp_done", resp_done, 0);
    check_eq("midrst_tx_byte", tx_byte, 0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    check_eq("midrst_no_done", done_cnt, 0);
    clear_log();
    send(1'b0, 8'h35, 16'h1A2F, 1'b1);
    check_eq("postrst_first", tx_byte, 8'h44);
    wait_idle("postrst_idle");
    check_frame("postrst_frame");
    check_eq("postrst_done_cnt", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
